// File: rtl/multicycle_pkg.sv
// Shared definitions for the multicycle control unit: state encodings, opcode
// and ALU operation constants, datapath select encodings, control word struct.
// Latency: n/a (types and pure functions). Backpressure: n/a.
package multicycle_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH0   = 4'd1,
    ST_FETCH1   = 4'd2,
    ST_FETCH2   = 4'd3,
    ST_DECODE   = 4'd4,
    ST_EXEC_R   = 4'd5,
    ST_EXEC_I   = 4'd6,
    ST_WB       = 4'd7,
    ST_MEM_ADDR = 4'd8,
    ST_MEM_RD   = 4'd9,
    ST_LD_WB    = 4'd10,
    ST_MEM_WR   = 4'd11,
    ST_BR_EVAL  = 4'd12,
    ST_JUMP     = 4'd13,
    ST_TRAP     = 4'd14
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE    = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_LB       = 6'b100000;
  localparam logic [5:0] OP_LBU      = 6'b100100;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_SB       = 6'b101000;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_J        = 6'b000010;

  // SPECIAL2 funct selecting count-leading-ones; anything else is CLZ
  localparam logic [5:0] FN_CLO = 6'b100001;

  // ALU operation codes
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_CLZ  = 6'b110000;
  localparam logic [5:0] ALU_CLO  = 6'b110001;
  localparam logic [5:0] ALU_IDLE = 6'b111111;

  // ALU B-operand select
  localparam logic [1:0] ASRC_RT   = 2'b00;
  localparam logic [1:0] ASRC_IMM  = 2'b01;
  localparam logic [1:0] ASRC_FOUR = 2'b10;
  localparam logic [1:0] ASRC_IDLE = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_MEM,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_t;

  // One cycle's worth of control outputs. alu_busy marks alu_code as a real
  // operation; when clear the top drives all ones at its own ALU width.
  typedef struct packed {
    logic       reg_write;
    logic       flag_load;
    logic       inst_reg_load;
    logic       mar_load;
    logic       mdr_load;
    logic       pc_load;
    logic       mem_enable;
    logic       rw;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       un_sign;
    logic       byte_sel;
    logic [1:0] alu_src;
    logic [1:0] pc_src;
    logic       alu_busy;
    logic [5:0] alu_code;
  } ctrl_t;

  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c          = '0;
    c.alu_src  = ASRC_IDLE;
    c.pc_src   = PCSRC_ALU;
    c.alu_code = ALU_IDLE;
    return c;
  endfunction

  function automatic op_class_t classify(input logic [5:0] op);
    op_class_t cls;
    case (op)
      OP_RTYPE, OP_SPECIAL2:               cls = CLS_RTYPE;
      OP_ADDI, OP_ADDIU:                   cls = CLS_ITYPE;
      OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB:  cls = CLS_MEM;
      OP_BEQ, OP_REGIMM, OP_BLEZ, OP_BGTZ: cls = CLS_BRANCH;
      OP_J:                                cls = CLS_JUMP;
      default:                             cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_byte_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags a timeout when the access overstays.
// Latency: expired is combinational from the registered count and ready.
// Backpressure: none; count saturates at MEM_TIMEOUT, ready holds the count.
// Ports: clk, rst_n (async active-low), clear (hold count at zero),
//        ready (access complete this cycle), expired (timeout this cycle).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic ready,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] count_q, count_d;

  // Held at zero outside wait states, so entering a wait state always
  // starts from zero without needing an explicit entry pulse.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!ready && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A ready in the same cycle as the limit completes the access instead.
  assign expired = !clear && !ready && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing and datapath strobes.
// Latency: zero-wait R/I 6 cycles, load 7, store 6, branch/jump 5; outputs decode registered state.
// Backpressure: FETCH1/MEM_RD/MEM_WR hold until mem_ready; timeout -> TRAP (or FETCH0).
// Ports: clk, reset (async active-low); opCode/funct from IR; cond_true
//        branch flag; mem_ready memory handshake; register/memory strobes,
//        datapath selects, aluSrc/pcSrc/aluCode, state and sticky trap.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int ALU_CODE_W  = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter bit HAS_TRAP    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opCode,
  input  logic [5:0]            funct,
  input  logic                  cond_true,
  input  logic                  mem_ready,
  output logic                  regWrite,
  output logic                  flagLoad,
  output logic                  instRegLoad,
  output logic                  marLoad,
  output logic                  mdrLoad,
  output logic                  pcLoad,
  output logic                  memEnable,
  output logic                  RW,
  output logic                  regDst,
  output logic                  mem_to_reg,
  output logic                  unSign,
  output logic                  byteSel,
  output logic [1:0]            aluSrc,
  output logic [1:0]            pcSrc,
  output logic [ALU_CODE_W-1:0] aluCode,
  output logic [3:0]            state,
  output logic                  trap
);

  // Where illegal opcodes and memory timeouts land.
  localparam state_t FAULT_ST = HAS_TRAP ? ST_TRAP : ST_FETCH0;

  state_t state_q, state_d;
  logic   trap_q, trap_d;
  logic   in_wait;
  logic   mem_expired;
  ctrl_t  ctrl;

  assign in_wait = (state_q == ST_FETCH1) || (state_q == ST_MEM_RD) ||
                   (state_q == ST_MEM_WR);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (!in_wait),
    .ready   (mem_ready),
    .expired (mem_expired)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH0;
      ST_FETCH0: state_d = ST_FETCH1;
      ST_FETCH1: begin
        if (mem_ready) begin
          state_d = ST_FETCH2;
        end else if (mem_expired) begin
          state_d = FAULT_ST;
        end
      end
      ST_FETCH2: state_d = ST_DECODE;
      ST_DECODE: begin
        case (classify(opCode))
          CLS_RTYPE:  state_d = ST_EXEC_R;
          CLS_ITYPE:  state_d = ST_EXEC_I;
          CLS_MEM:    state_d = ST_MEM_ADDR;
          CLS_BRANCH: state_d = ST_BR_EVAL;
          CLS_JUMP:   state_d = ST_JUMP;
          default:    state_d = FAULT_ST;
        endcase
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_WB;
      ST_WB:                state_d = ST_FETCH0;
      // Only memory opcodes reach here; anything not a load is a store.
      ST_MEM_ADDR: state_d = is_load(opCode) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD: begin
        if (mem_ready) begin
          state_d = ST_LD_WB;
        end else if (mem_expired) begin
          state_d = FAULT_ST;
        end
      end
      ST_LD_WB: state_d = ST_FETCH0;
      ST_MEM_WR: begin
        if (mem_ready) begin
          state_d = ST_FETCH0;
        end else if (mem_expired) begin
          state_d = FAULT_ST;
        end
      end
      ST_BR_EVAL, ST_JUMP: state_d = ST_FETCH0;
      ST_TRAP:             state_d = ST_TRAP;
      default:             state_d = ST_FETCH0;
    endcase
    trap_d = trap_q | (state_d == ST_TRAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

  // Output decode: registered state plus the stable IR fields; cond_true
  // only reaches pcLoad in BR_EVAL.
  always_comb begin
    ctrl = ctrl_default();
    case (state_q)
      ST_FETCH0: ctrl.mar_load = 1'b1;
      ST_FETCH1: begin
        ctrl.mem_enable = 1'b1;
        ctrl.rw         = 1'b1;
      end
      ST_FETCH2: begin
        ctrl.inst_reg_load = 1'b1;
        ctrl.pc_load       = 1'b1;
        ctrl.alu_src       = ASRC_FOUR;
        ctrl.alu_busy      = 1'b1;
        ctrl.alu_code      = ALU_ADDU;
        ctrl.pc_src        = PCSRC_ALU;
      end
      ST_EXEC_R: begin
        ctrl.alu_src   = ASRC_RT;
        ctrl.flag_load = 1'b1;
        ctrl.alu_busy  = 1'b1;
        if (opCode == OP_SPECIAL2) begin
          ctrl.alu_code = (funct == FN_CLO) ? ALU_CLO : ALU_CLZ;
        end else begin
          ctrl.alu_code = funct;
        end
      end
      ST_EXEC_I: begin
        ctrl.alu_src   = ASRC_IMM;
        ctrl.flag_load = 1'b1;
        ctrl.alu_busy  = 1'b1;
        ctrl.alu_code  = (opCode == OP_ADDIU) ? ALU_ADDU : ALU_ADD;
        ctrl.un_sign   = (opCode == OP_ADDIU);
      end
      ST_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = (classify(opCode) == CLS_RTYPE);
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src  = ASRC_IMM;
        ctrl.alu_busy = 1'b1;
        ctrl.alu_code = ALU_ADDU;
        ctrl.mar_load = 1'b1;
      end
      ST_MEM_RD: begin
        ctrl.mem_enable = 1'b1;
        ctrl.rw         = 1'b1;
        ctrl.mdr_load   = 1'b1;
        ctrl.byte_sel   = is_byte_load(opCode);
        ctrl.un_sign    = (opCode == OP_LBU);
      end
      ST_LD_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.byte_sel   = is_byte_load(opCode);
        ctrl.un_sign    = (opCode == OP_LBU);
      end
      ST_MEM_WR: begin
        ctrl.mem_enable = 1'b1;
        ctrl.byte_sel   = (opCode == OP_SB);
      end
      ST_BR_EVAL: begin
        ctrl.alu_src   = ASRC_RT;
        ctrl.alu_busy  = 1'b1;
        ctrl.alu_code  = ALU_SUB;
        ctrl.flag_load = 1'b1;
        ctrl.pc_load   = cond_true;
        ctrl.pc_src    = PCSRC_BRANCH;
      end
      ST_JUMP: begin
        ctrl.pc_load = 1'b1;
        ctrl.pc_src  = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign regWrite    = ctrl.reg_write;
  assign flagLoad    = ctrl.flag_load;
  assign instRegLoad = ctrl.inst_reg_load;
  assign marLoad     = ctrl.mar_load;
  assign mdrLoad     = ctrl.mdr_load;
  assign pcLoad      = ctrl.pc_load;
  assign memEnable   = ctrl.mem_enable;
  assign RW          = ctrl.rw;
  assign regDst      = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign unSign      = ctrl.un_sign;
  assign byteSel     = ctrl.byte_sel;
  assign aluSrc      = ctrl.alu_src;
  assign pcSrc       = ctrl.pc_src;
  // Idle is all ones at the configured width; real codes zero-extend/truncate.
  assign aluCode     = ctrl.alu_busy ? ALU_CODE_W'(ctrl.alu_code) : '1;
  assign state       = state_q;
  assign trap        = trap_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expectation table over an
// instruction stream, plus wait-timeout, illegal-opcode and async-reset cases.
// A second instance built without trap support shares the stimulus.
module tb_multicycle_control;

  // State encodings
  localparam logic [3:0] S_IDLE = 4'd0, S_F0 = 4'd1, S_F1 = 4'd2, S_F2 = 4'd3,
                         S_DEC = 4'd4, S_XR = 4'd5, S_XI = 4'd6, S_WB = 4'd7,
                         S_MA = 4'd8, S_MR = 4'd9, S_LW = 4'd10, S_MW = 4'd11,
                         S_BR = 4'd12, S_JP = 4'd13, S_TR = 4'd14;

  // Strobe bits: {regWrite, flagLoad, instRegLoad, marLoad, mdrLoad, pcLoad,
  //               memEnable, RW, regDst, mem_to_reg, unSign, byteSel}
  localparam logic [11:0] RWR = 12'h800, FLG = 12'h400, IRL = 12'h200,
                          MAR = 12'h100, MDR = 12'h080, PCL = 12'h040,
                          MEN = 12'h020, RDB = 12'h010, RDST = 12'h008,
                          M2R = 12'h004, UNS = 12'h002, BYT = 12'h001,
                          NONE = 12'h000;

  localparam logic [5:0] A_ADD = 6'h20, A_ADDU = 6'h21, A_SUB = 6'h22,
                         A_CLZ = 6'h30, A_IDLE = 6'h3F;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        cond;
    logic        rdy;
    logic [3:0]  st;
    logic [11:0] strb;
    logic [1:0]  asrc;
    logic [1:0]  psrc;
    logic [5:0]  alu;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [5:0] opCode, funct;
  logic       cond_true, mem_ready;

  logic       regWrite, flagLoad, instRegLoad, marLoad, mdrLoad, pcLoad;
  logic       memEnable, RW, regDst, mem_to_reg, unSign, byteSel;
  logic [1:0] aluSrc, pcSrc;
  logic [5:0] aluCode;
  logic [3:0] state;
  logic       trap;

  logic       nt_regWrite, nt_flagLoad, nt_instRegLoad, nt_marLoad, nt_mdrLoad;
  logic       nt_pcLoad, nt_memEnable, nt_RW, nt_regDst, nt_mem_to_reg;
  logic       nt_unSign, nt_byteSel;
  logic [1:0] nt_aluSrc, nt_pcSrc;
  logic [5:0] nt_aluCode;
  logic [3:0] nt_state;
  logic       nt_trap;

  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];

  multicycle_control dut (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct),
    .cond_true(cond_true), .mem_ready(mem_ready),
    .regWrite(regWrite), .flagLoad(flagLoad), .instRegLoad(instRegLoad),
    .marLoad(marLoad), .mdrLoad(mdrLoad), .pcLoad(pcLoad),
    .memEnable(memEnable), .RW(RW), .regDst(regDst), .mem_to_reg(mem_to_reg),
    .unSign(unSign), .byteSel(byteSel), .aluSrc(aluSrc), .pcSrc(pcSrc),
    .aluCode(aluCode), .state(state), .trap(trap)
  );

  multicycle_control #(.HAS_TRAP(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct),
    .cond_true(cond_true), .mem_ready(mem_ready),
    .regWrite(nt_regWrite), .flagLoad(nt_flagLoad),
    .instRegLoad(nt_instRegLoad), .marLoad(nt_marLoad),
    .mdrLoad(nt_mdrLoad), .pcLoad(nt_pcLoad), .memEnable(nt_memEnable),
    .RW(nt_RW), .regDst(nt_regDst), .mem_to_reg(nt_mem_to_reg),
    .unSign(nt_unSign), .byteSel(nt_byteSel), .aluSrc(nt_aluSrc),
    .pcSrc(nt_pcSrc), .aluCode(nt_aluCode), .state(nt_state), .trap(nt_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  wire [11:0] strb = {regWrite, flagLoad, instRegLoad, marLoad, mdrLoad, pcLoad,
                      memEnable, RW, regDst, mem_to_reg, unSign, byteSel};
  wire [25:0] outs = {state, strb, aluSrc, pcSrc, aluCode};

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn,
                     input logic cond, input logic rdy, input logic [3:0] st,
                     input logic [11:0] sb, input logic [1:0] asrc,
                     input logic [1:0] psrc, input logic [5:0] alu);
    vec_t r;
    r.op = op; r.fn = fn; r.cond = cond; r.rdy = rdy; r.st = st;
    r.strb = sb; r.asrc = asrc; r.psrc = psrc; r.alu = alu;
    vecs.push_back(r);
  endtask

  // Fetch rows common to every instruction (mem_ready high in FETCH1)
  task automatic add_fetch(input logic [5:0] op, input logic [5:0] fn,
                           input logic cond);
    add(op, fn, cond, 1'b1, S_F0,  MAR,       2'b11, 2'b00, A_IDLE);
    add(op, fn, cond, 1'b1, S_F1,  MEN | RDB, 2'b11, 2'b00, A_IDLE);
    add(op, fn, cond, 1'b1, S_F2,  IRL | PCL, 2'b10, 2'b00, A_ADDU);
    add(op, fn, cond, 1'b1, S_DEC, NONE,      2'b11, 2'b00, A_IDLE);
  endtask

  // Holds reset for one cycle, checks the reset state, releases it and
  // returns at the falling edge of the first FETCH0 cycle.
  task automatic do_reset();
    reset = 1'b0; opCode = 6'h00; funct = 6'h00;
    cond_true = 1'b0; mem_ready = 1'b1;
    @(negedge clk); #1;
    check("reset_outputs", {6'b0, outs},
          {6'b0, S_IDLE, NONE, 2'b11, 2'b00, A_IDLE});
    check("reset_trap", {31'b0, trap}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // ADDIU 0x2401002C
    add_fetch(6'b001001, 6'b101100, 1'b0);
    add(6'b001001, 6'b101100, 1'b0, 1'b1, S_XI, FLG | UNS, 2'b01, 2'b00, A_ADDU);
    add(6'b001001, 6'b101100, 1'b0, 1'b1, S_WB, RWR,       2'b11, 2'b00, A_IDLE);
    // LBU 0x90220000, mem_ready low for three MEM_RD cycles
    add_fetch(6'b100100, 6'b000000, 1'b0);
    add(6'b100100, 6'b000000, 1'b0, 1'b1, S_MA, MAR, 2'b01, 2'b00, A_ADDU);
    for (int k = 0; k < 4; k++)
      add(6'b100100, 6'b000000, 1'b0, (k == 3), S_MR,
          MEN | RDB | MDR | BYT | UNS, 2'b11, 2'b00, A_IDLE);
    add(6'b100100, 6'b000000, 1'b0, 1'b1, S_LW, RWR | M2R | BYT | UNS,
        2'b11, 2'b00, A_IDLE);
    // R-type ADD: aluCode is funct
    add_fetch(6'b000000, 6'b100000, 1'b0);
    add(6'b000000, 6'b100000, 1'b0, 1'b1, S_XR, FLG,        2'b00, 2'b00, A_ADD);
    add(6'b000000, 6'b100000, 1'b0, 1'b1, S_WB, RWR | RDST, 2'b11, 2'b00, A_IDLE);
    // SPECIAL2 with the same funct: CLZ, not pass-through
    add_fetch(6'b011100, 6'b100000, 1'b0);
    add(6'b011100, 6'b100000, 1'b0, 1'b1, S_XR, FLG,        2'b00, 2'b00, A_CLZ);
    add(6'b011100, 6'b100000, 1'b0, 1'b1, S_WB, RWR | RDST, 2'b11, 2'b00, A_IDLE);
    // SB: write, RW=0, byteSel
    add_fetch(6'b101000, 6'b000000, 1'b0);
    add(6'b101000, 6'b000000, 1'b0, 1'b1, S_MA, MAR,       2'b01, 2'b00, A_ADDU);
    add(6'b101000, 6'b000000, 1'b0, 1'b1, S_MW, MEN | BYT, 2'b11, 2'b00, A_IDLE);
    // BGTZ 0x1C60FFFD taken, then not taken
    add_fetch(6'b000111, 6'b111101, 1'b1);
    add(6'b000111, 6'b111101, 1'b1, 1'b1, S_BR, FLG | PCL, 2'b00, 2'b01, A_SUB);
    add_fetch(6'b000111, 6'b111101, 1'b0);
    add(6'b000111, 6'b111101, 1'b0, 1'b1, S_BR, FLG,       2'b00, 2'b01, A_SUB);
    // J
    add_fetch(6'b000010, 6'b000000, 1'b0);
    add(6'b000010, 6'b000000, 1'b0, 1'b1, S_JP, PCL,       2'b11, 2'b10, A_IDLE);
    // Back to fetch after the jump
    add(6'b000000, 6'b000000, 1'b0, 1'b1, S_F0, MAR,       2'b11, 2'b00, A_IDLE);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      opCode = vecs[i].op; funct = vecs[i].fn;
      cond_true = vecs[i].cond; mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d", i), {6'b0, outs},
            {6'b0, vecs[i].st, vecs[i].strb, vecs[i].asrc, vecs[i].psrc,
             vecs[i].alu});
      @(negedge clk);
    end

    // mem_ready arriving on the last allowed wait cycle still completes
    do_reset();
    opCode = 6'b001001; mem_ready = 1'b0;
    @(negedge clk);
    repeat (15) @(negedge clk);
    #1 check("ready_edge_in_f1", {28'b0, state}, {28'b0, S_F1});
    mem_ready = 1'b1;
    @(negedge clk); #1;
    check("ready_edge_f2", {28'b0, state}, {28'b0, S_F2});
    check("ready_edge_trap", {31'b0, trap}, 32'd0);

    // Fetch timeout: TRAP 16 cycles after FETCH1 entry
    do_reset();
    mem_ready = 1'b0;
    @(negedge clk); #1;
    check("timeout_f1_entry", {28'b0, state}, {28'b0, S_F1});
    repeat (15) @(negedge clk);
    #1 check("timeout_last_wait", {28'b0, state}, {28'b0, S_F1});
    @(negedge clk); #1;
    check("timeout_state", {28'b0, state}, {28'b0, S_TR});
    check("timeout_trap", {31'b0, trap}, 32'd1);
    check("timeout_mem_en", {31'b0, memEnable}, 32'd0);
    check("timeout_notrap_state", {28'b0, nt_state}, {28'b0, S_F0});
    check("timeout_notrap_trap", {31'b0, nt_trap}, 32'd0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("trap_sticky_state", {28'b0, state}, {28'b0, S_TR});
    check("trap_sticky_trap", {31'b0, trap}, 32'd1);

    // Illegal opcode
    do_reset();
    opCode = 6'b111111;
    repeat (3) @(negedge clk);
    #1 check("illegal_decode", {28'b0, state}, {28'b0, S_DEC});
    check("illegal_decode_trap", {31'b0, trap}, 32'd0);
    @(negedge clk); #1;
    check("illegal_state", {28'b0, state}, {28'b0, S_TR});
    check("illegal_trap", {31'b0, trap}, 32'd1);
    check("illegal_outputs", {6'b0, outs},
          {6'b0, S_TR, NONE, 2'b11, 2'b00, A_IDLE});
    check("illegal_notrap_state", {28'b0, nt_state}, {28'b0, S_F0});

    // Asynchronous reset in the middle of a stalled SW
    do_reset();
    opCode = 6'b101011;
    repeat (4) @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk); #1;
    check("sw_wr_outputs", {6'b0, outs},
          {6'b0, S_MW, MEN, 2'b11, 2'b00, A_IDLE});
    #1 reset = 1'b0;
    #1;
    check("async_rst_mem_en", {31'b0, memEnable}, 32'd0);
    check("async_rst_state", {28'b0, state}, {28'b0, S_IDLE});
    check("async_rst_trap", {31'b0, trap}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_CODE_W, default 6, width of aluCode; values wider than 6 zero-extend, narrower truncate MSBs.
REQ-002 Parameter MEM_TIMEOUT, default 15, maximum wait cycles per memory access without mem_ready.
REQ-003 Parameter HAS_TRAP, default 1: 1 = illegal opcode/timeout enters TRAP; 0 = treated as NOP, return to FETCH0.
REQ-004 clk  input  1  rising-edge clock, sole clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 opCode  input  6  IR[31:26], stable from DECODE onward.
REQ-007 funct  input  6  IR[5:0].
REQ-008 cond_true  input  1  branch condition from flag register, sampled in BR_EVAL.
REQ-009 mem_ready  input  1  memory access complete.
REQ-010 regWrite, flagLoad, instRegLoad, marLoad, mdrLoad, pcLoad, memEnable  output  1 each  register/memory strobes.
REQ-011 RW  output  1  1 = read, 0 = write; valid only with memEnable.
REQ-012 regDst, mem_to_reg, unSign, byteSel  output  1 each  datapath selects.
REQ-013 aluSrc  output  2  00 rt, 01 sign-extended immediate, 10 constant 4, 11 idle.
REQ-014 pcSrc  output  2  00 ALU result, 01 branch target, 10 jump target.
REQ-015 aluCode  output  ALU_CODE_W  ALU operation; all ones = idle.
REQ-016 state  output  4  current state encoding; trap  output  1  sticky fault.

Function
REQ-017 Defaults in every state unless listed: all strobes 0, RW 0, selects 0, aluSrc 11, aluCode all ones, pcSrc 00.
REQ-018 IDLE -> FETCH0 on the first clk edge after reset release.
REQ-019 FETCH0: marLoad=1 -> FETCH1.
REQ-020 FETCH1: memEnable=1, RW=1; hold until mem_ready=1 -> FETCH2.
REQ-021 FETCH2: instRegLoad=1, pcLoad=1, aluSrc=10, aluCode=ALU_ADDU, pcSrc=00 -> DECODE.
REQ-022 DECODE, no strobes: 000000/011100 -> EXEC_R; 001000/001001 -> EXEC_I; 100011/100000/100100/101011/101000 -> MEM_ADDR; 000100/000001/000110/000111 -> BR_EVAL; 000010 -> JUMP; any other -> TRAP (HAS_TRAP=1) or FETCH0.
REQ-023 EXEC_R: aluSrc=00, flagLoad=1; aluCode=funct for 000000, ALU_CLO if funct=100001 else ALU_CLZ for 011100 -> WB.
REQ-024 EXEC_I: aluSrc=01, flagLoad=1, aluCode=ALU_ADD (001000) or ALU_ADDU with unSign=1 (001001) -> WB.
REQ-025 WB: regWrite=1, regDst=1 only for R-type, mem_to_reg=0 -> FETCH0.
REQ-026 MEM_ADDR: aluSrc=01, aluCode=ALU_ADDU, marLoad=1 -> MEM_RD (loads) or MEM_WR (stores).
REQ-027 MEM_RD: memEnable=1, RW=1, mdrLoad=1, byteSel=1 for LB/LBU, unSign=1 for LBU; hold until mem_ready -> LD_WB.
REQ-028 LD_WB: regWrite=1, mem_to_reg=1, regDst=0, byteSel/unSign as MEM_RD -> FETCH0.
REQ-029 MEM_WR: memEnable=1, RW=0, byteSel=1 for SB; hold until mem_ready -> FETCH0.
REQ-030 BR_EVAL: aluSrc=00, aluCode=ALU_SUB, flagLoad=1; pcLoad=cond_true, pcSrc=01 -> FETCH0.
REQ-031 JUMP: pcLoad=1, pcSrc=10 -> FETCH0.
REQ-032 TRAP: defaults, trap=1; remains until reset.
REQ-033 Wait counter clears on entry to FETCH1/MEM_RD/MEM_WR, increments each cycle mem_ready=0; at count=MEM_TIMEOUT with mem_ready=0 -> TRAP (or FETCH0 if HAS_TRAP=0); mem_ready=1 in the same cycle wins.
REQ-034 Zero-wait latency (mem_ready high on first wait cycle): R/I-type 6 cycles, load 7, store 6, branch/jump 5.
REQ-035 Outputs are functions of registered state, opCode, funct and (BR_EVAL only) cond_true; no other input-to-output paths.

Reset
REQ-036 reset=0 asynchronously forces state=IDLE, wait counter=0, trap=0; all outputs take defaults immediately, aborting any access (memEnable drops without a clock).

Structure
REQ-037 Shared package multicycle_pkg holds state encodings, opcode constants, ALU_ADD=100000, ALU_ADDU=100001, ALU_SUB=100010, ALU_CLZ=110000, ALU_CLO=110001, aluSrc/pcSrc encodings.
REQ-038 One sub-module mem_wait_timer (clear, ready in; expired out, MEM_TIMEOUT parameter).

Verification
REQ-039 ADDIU (0x2401002C), mem_ready tied 1 -> states FETCH0,FETCH1,FETCH2,DECODE,EXEC_I,WB; regWrite one cycle, unSign=1, aluCode=100001.
REQ-040 LBU (0x90220000), mem_ready delayed 3 cycles in MEM_RD -> mdrLoad held 4 cycles, byteSel=unSign=1, LD_WB mem_to_reg=1, total 10 cycles.
REQ-041 BGTZ (0x1C60FFFD) with cond_true=1 then 0 -> pcLoad=1/pcSrc=01 first case, pcLoad=0 second; both return to FETCH0 after 5 cycles.
REQ-042 mem_ready held 0, MEM_TIMEOUT=15 -> TRAP entered 16 cycles after FETCH1 entry, trap=1 sticky; HAS_TRAP=0 build returns to FETCH0.
REQ-043 opCode 111111 -> TRAP; reset asserted mid-MEM_WR -> memEnable=0 before next edge, state=IDLE, trap=0.
